// File: rtl/svc_rv_scoreboard.sv
// Register-pending scoreboard for variable-latency writers. It allocates a tag at issue,
// clears pending state on possibly out-of-order completions, and produces the ID stalls.
module svc_rv_scoreboard #(
  parameter  int NREG       = 32,
  parameter  int NCPL       = 2,
  parameter  int TAG_W      = 3,
  parameter  int CPL_BYPASS = 1,
  localparam int RW         = $clog2(NREG),
  localparam int NTAG       = 2 ** TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    rs1_id,
  input  logic [RW-1:0]    rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic             is_long_id,
  input  logic             iss_valid,
  input  logic [RW-1:0]    iss_rd,
  output logic [TAG_W-1:0] iss_tag,
  input  logic [NCPL-1:0]  cpl_valid,
  input  logic [TAG_W-1:0] cpl_tag [NCPL],
  input  logic [RW-1:0]    cpl_rd  [NCPL],
  output logic             tag_avail,
  output logic             data_stall,
  output logic             tag_stall,
  output logic [TAG_W:0]   inflight,
  output logic             err
);

  localparam bit BYPASS = (CPL_BYPASS != 0);

  logic [NREG-1:0]  pend_q, pend_d;
  logic [TAG_W-1:0] owner_q [NREG];
  logic [TAG_W-1:0] owner_d [NREG];
  logic [NTAG-1:0]  tag_busy_q, tag_busy_d;
  logic [RW-1:0]    tag_rd_q [NTAG];
  logic [RW-1:0]    tag_rd_d [NTAG];
  logic [TAG_W:0]   inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [TAG_W-1:0] free_tag;
  logic             iss_ok;
  logic [NCPL-1:0]  cpl_dup;
  logic [NCPL-1:0]  cpl_legal;
  logic [NREG-1:0]  cpl_clear;
  logic [TAG_W:0]   n_done;
  logic             rs1_haz, rs2_haz;

  // Lowest-index free tag; freed tags only become visible here after they are registered.
  always_comb begin
    free_tag = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (!tag_busy_q[i]) free_tag = TAG_W'(i);
    end
  end

  assign tag_avail = ~&tag_busy_q;
  assign iss_tag   = free_tag;
  assign iss_ok    = iss_valid && tag_avail;

  always_comb begin
    cpl_dup   = '0;
    cpl_legal = '0;
    cpl_clear = '0;
    for (int c = 0; c < NCPL; c++) begin
      for (int k = 0; k < NCPL; k++) begin
        if (k != c && cpl_valid[k] && cpl_tag[k] == cpl_tag[c]) cpl_dup[c] = 1'b1;
      end
      cpl_legal[c] = cpl_valid[c] && !cpl_dup[c] && tag_busy_q[cpl_tag[c]]
                     && (tag_rd_q[cpl_tag[c]] == cpl_rd[c]);
      // Only the newest writer of a register may release its pending bit.
      if (cpl_legal[c] && owner_q[cpl_rd[c]] == cpl_tag[c]) cpl_clear[cpl_rd[c]] = 1'b1;
    end
  end

  always_comb begin
    rs1_haz = rs1_used_id && (rs1_id != '0) && pend_q[rs1_id]
              && !(BYPASS && cpl_clear[rs1_id]);
    rs2_haz = rs2_used_id && (rs2_id != '0) && pend_q[rs2_id]
              && !(BYPASS && cpl_clear[rs2_id]);
  end

  assign data_stall = rs1_haz || rs2_haz;
  assign tag_stall  = is_long_id && !tag_avail;
  assign inflight   = inflight_q;
  assign err        = err_q;

  always_comb begin
    pend_d     = pend_q;
    owner_d    = owner_q;
    tag_busy_d = tag_busy_q;
    tag_rd_d   = tag_rd_q;
    err_d      = err_q;
    n_done     = '0;
    for (int c = 0; c < NCPL; c++) begin
      if (cpl_legal[c]) begin
        tag_busy_d[cpl_tag[c]] = 1'b0;
        n_done = n_done + (TAG_W + 1)'(1);
      end
      if (cpl_valid[c] && !cpl_legal[c]) err_d = 1'b1;
    end
    pend_d = pend_d & ~cpl_clear;
    if (iss_valid && !tag_avail) err_d = 1'b1;
    // Issue is applied after completions so it wins on a same-register collision.
    if (iss_ok) begin
      tag_busy_d[free_tag] = 1'b1;
      tag_rd_d[free_tag]   = iss_rd;
      if (iss_rd != '0) begin
        pend_d[iss_rd]  = 1'b1;
        owner_d[iss_rd] = free_tag;
      end
    end
    inflight_d = inflight_q + (iss_ok ? (TAG_W + 1)'(1) : '0) - n_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      tag_busy_q <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) owner_q[i] <= '0;
      for (int i = 0; i < NTAG; i++) tag_rd_q[i] <= '0;
    end else begin
      pend_q     <= pend_d;
      owner_q    <= owner_d;
      tag_busy_q <= tag_busy_d;
      tag_rd_q   <= tag_rd_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Scoreboard bench for svc_rv_scoreboard: the driver pushes expected outputs from an
// in-flight-operation reference model, and a negedge monitor pops and compares them.
module tb_svc_rv_scoreboard;

  localparam int NTAG = 8;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_id, rs2_id;
  logic       rs1_used_id, rs2_used_id;
  logic       is_long_id;
  logic       iss_valid;
  logic [4:0] iss_rd;
  logic [2:0] iss_tag;
  logic [1:0] cpl_valid;
  logic [2:0] cpl_tag [2];
  logic [4:0] cpl_rd  [2];
  logic       tag_avail, data_stall, tag_stall, err;
  logic [3:0] inflight;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stall;
    logic       tstall;
    logic       avail;
    logic       err;
    logic [2:0] tag;
    logic [3:0] infl;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a set of in-flight ops, each with its rd and issue sequence number.
  bit m_busy   [NTAG];
  int m_rd     [NTAG];
  int m_seq    [NTAG];
  int m_newest [32];
  bit m_err;
  int seq_ctr;

  svc_rv_scoreboard #(.NREG(32), .NCPL(2), .TAG_W(3), .CPL_BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .is_long_id(is_long_id),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_rd(cpl_rd),
    .tag_avail(tag_avail), .data_stall(data_stall), .tag_stall(tag_stall),
    .inflight(inflight), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int t = 0; t < NTAG; t++) if (m_busy[t]) n++;
    return n;
  endfunction

  function automatic int m_lowest_free();
    for (int t = 0; t < NTAG; t++) if (!m_busy[t]) return t;
    return 0;
  endfunction

  // A register is pending while its most recently issued writer is still in flight.
  function automatic bit m_pend(int r);
    if (r == 0) return 1'b0;
    for (int t = 0; t < NTAG; t++)
      if (m_busy[t] && m_rd[t] == r && m_seq[t] == m_newest[r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_legal(int c);
    int o = 1 - c;
    if (!cpl_valid[c]) return 1'b0;
    if (cpl_valid[o] && cpl_tag[o] == cpl_tag[c]) return 1'b0;
    return m_busy[cpl_tag[c]] && (m_rd[cpl_tag[c]] == int'(cpl_rd[c]));
  endfunction

  function automatic bit m_cleared(int r);
    for (int c = 0; c < 2; c++)
      if (m_legal(c) && int'(cpl_rd[c]) == r && m_seq[cpl_tag[c]] == m_newest[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0; is_long_id = 1'b0;
    cpl_valid = '0;
    cpl_tag[0] = '0; cpl_tag[1] = '0; cpl_rd[0] = '0; cpl_rd[1] = '0;
  endtask

  task automatic set_cpl(int c, int tag, int rd);
    cpl_valid[c] = 1'b1;
    cpl_tag[c]   = 3'(tag);
    cpl_rd[c]    = 5'(rd);
  endtask

  // One clock of stimulus: predict this cycle's outputs, push them, then advance the model.
  task automatic applyStimulus();
    exp_t e;
    bit   leg [2];
    int   n;
    if (rst) begin
      for (int t = 0; t < NTAG; t++) m_busy[t] = 1'b0;
      m_err = 1'b0;
    end else begin
      n        = m_count();
      e.avail  = (n < NTAG);
      e.tag    = 3'(m_lowest_free());
      e.infl   = 4'(n);
      e.err    = m_err;
      e.tstall = is_long_id && !e.avail;
      e.stall  = (rs1_used_id && m_pend(int'(rs1_id)) && !m_cleared(int'(rs1_id)))
              || (rs2_used_id && m_pend(int'(rs2_id)) && !m_cleared(int'(rs2_id)));
      exp_q.push_back(e);
      for (int c = 0; c < 2; c++) begin
        leg[c] = m_legal(c);
        if (cpl_valid[c] && !leg[c]) m_err = 1'b1;
      end
      if (iss_valid && !e.avail) m_err = 1'b1;
      for (int c = 0; c < 2; c++) if (leg[c]) m_busy[cpl_tag[c]] = 1'b0;
      if (iss_valid && e.avail) begin
        m_busy[e.tag] = 1'b1;
        m_rd[e.tag]   = int'(iss_rd);
        seq_ctr++;
        m_seq[e.tag]  = seq_ctr;
        m_newest[iss_rd] = seq_ctr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = exp_q.pop_front();
    cmp("data_stall", int'(data_stall), int'(e.stall));
    cmp("tag_stall",  int'(tag_stall),  int'(e.tstall));
    cmp("tag_avail",  int'(tag_avail),  int'(e.avail));
    cmp("err",        int'(err),        int'(e.err));
    cmp("inflight",   int'(inflight),   int'(e.infl));
    if (e.avail) cmp("iss_tag", int'(iss_tag), int'(e.tag));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput();
  end

  task automatic issue(int rd);
    idle();
    iss_valid = 1'b1; iss_rd = 5'(rd);
    applyStimulus();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    int pick, cnt;
    int cand [NTAG];
    for (int r = 0; r < 32; r++) m_newest[r] = -1;
    seq_ctr = 0;
    m_err   = 1'b0;
    rs1_id = '0; rs2_id = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    idle();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    // Reset state with a used source that has never been written
    rs1_id = 5'd5; rs1_used_id = 1'b1;
    applyStimulus();

    // Basic hazard and same-cycle release
    issue(5);
    idle();
    repeat (3) applyStimulus();
    set_cpl(0, 0, 5);
    applyStimulus();
    idle();
    applyStimulus();

    // WAW: older completion must not release the newer writer
    rs1_used_id = 1'b0; rs2_id = 5'd7; rs2_used_id = 1'b1;
    issue(7);
    issue(7);
    idle(); set_cpl(0, 0, 7); applyStimulus();
    idle(); applyStimulus();
    set_cpl(0, 1, 7); applyStimulus();
    idle(); applyStimulus();

    // Fill the pool, then free tag 3 on channel 1
    rs2_used_id = 1'b0;
    for (int i = 0; i < NTAG; i++) issue((i == 2) ? 9 : 10 + i);
    idle(); is_long_id = 1'b1; applyStimulus();
    set_cpl(1, 3, 13); applyStimulus();
    idle(); is_long_id = 1'b1; applyStimulus();

    // Same-cycle issue and completion to rd 9, then dual-channel completion
    rs1_id = 5'd9; rs1_used_id = 1'b1;
    idle(); iss_valid = 1'b1; iss_rd = 5'd9; set_cpl(0, 2, 9); applyStimulus();
    idle(); applyStimulus();
    set_cpl(0, 3, 9); applyStimulus();
    idle(); set_cpl(0, 0, 10); set_cpl(1, 1, 11); applyStimulus();
    idle(); applyStimulus();

    // Illegal completions: wrong rd, duplicate tag, free tag
    idle(); set_cpl(0, 4, 5); applyStimulus();
    idle(); applyStimulus();
    set_cpl(0, 4, 14); set_cpl(1, 4, 14); applyStimulus();
    idle(); set_cpl(1, 0, 10); applyStimulus();
    idle(); applyStimulus();

    // Reset with four tags in flight
    do_reset();
    for (int i = 0; i < 4; i++) issue(20 + i);
    rs1_id = 5'd20; rs1_used_id = 1'b1;
    do_reset();
    idle(); is_long_id = 1'b1; applyStimulus();

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        continue;
      end
      rs1_id = 5'($urandom_range(0, 7));
      rs2_id = 5'($urandom_range(0, 7));
      rs1_used_id = 1'($urandom_range(0, 1));
      rs2_used_id = 1'($urandom_range(0, 1));
      is_long_id  = 1'($urandom_range(0, 1));
      if (m_count() < NTAG && $urandom_range(0, 99) < 45) begin
        iss_valid = 1'b1;
        iss_rd = 5'($urandom_range(0, 7));
      end
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 99) < 35) begin
          cnt = 0;
          for (int t = 0; t < NTAG; t++)
            if (m_busy[t] && !(c == 1 && cpl_valid[0] && int'(cpl_tag[0]) == t)) begin
              cand[cnt] = t;
              cnt++;
            end
          if (cnt > 0) begin
            pick = cand[$urandom_range(0, cnt - 1)];
            set_cpl(c, pick, m_rd[pick]);
          end
        end
      end
      applyStimulus();
    end

    idle();
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svc_rv_scoreboard.md
# svc_rv_scoreboard

Register-pending scoreboard for the RISC-V pipeline. It replaces stage-position comparison with explicit tracking of in-flight variable-latency producers: multi-cycle loads through caches or external memory, division, and CSR/M results arriving on independent writeback channels. It sits beside the existing hazard logic in ID, allocates a tag for every long-latency writer at its issue point and clears pending state as completions return, possibly out of order. It generates the ID data-hazard stall and the tag-exhaustion stall.

## Interface
- `NREG`, 32: number of architectural registers; index width is `$clog2(NREG)`; register 0 is never tracked.
- `NCPL`, 2: number of independent completion channels (1..4).
- `TAG_W`, 3: tag width; `2**TAG_W` long-latency ops may be in flight at once.
- `CPL_BYPASS`, 1: 1 = a completion in cycle N clears a hazard in cycle N; 0 = it clears in cycle N+1.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rs1_id`, `rs2_id` in `$clog2(NREG)` each: ID source registers.
- `rs1_used_id`, `rs2_used_id` in 1 each: the corresponding source is actually read.
- `is_long_id` in 1: the ID instruction is a long-latency writer and will need a tag.
- `iss_valid` in 1: a long-latency writer issues this cycle; this is the non-speculative point, so no flush path exists.
- `iss_rd` in `$clog2(NREG)`: destination register of the issuing op.
- `iss_tag` out `TAG_W`: tag assigned to the issuing op; valid whenever `tag_avail`=1.
- `cpl_valid[NCPL]` in 1 each: completion on channel c.
- `cpl_tag[NCPL]` in `TAG_W` each: tag being completed.
- `cpl_rd[NCPL]` in `$clog2(NREG)` each: destination of the completion, checked against the tag's recorded rd.
- `tag_avail` out 1: at least one free tag.
- `data_stall` out 1: an ID source is pending.
- `tag_stall` out 1: `is_long_id` && !`tag_avail`.
- `inflight` out `TAG_W+1`: number of allocated tags.
- `err` out 1, sticky: an illegal completion was seen.

## Operation
- State:
  - `pend[NREG]` bit plus `owner[NREG]` tag per register.
  - `tag_busy[2**TAG_W]` bit plus `tag_rd` per tag.
  - `inflight` counter.
  - `err` flag.
- Allocation: `iss_tag` is the lowest-index free tag, computed combinationally from `tag_busy`. Issue sets `tag_busy[iss_tag]`, `tag_rd[iss_tag]`=`iss_rd`, `pend[iss_rd]`=1 and `owner[iss_rd]`=`iss_tag`.
  - If `iss_rd`==0, the tag is still allocated but no `pend` bit is set.
  - `iss_valid` while !`tag_avail` is illegal: it sets `err` and is otherwise ignored.
- Completion on channel c:
  - Requires `tag_busy[cpl_tag]`=1 and `tag_rd[cpl_tag]`==`cpl_rd`; otherwise set `err` and ignore the completion.
  - A legal completion clears `tag_busy[cpl_tag]`.
  - It clears `pend[cpl_rd]` only if `owner[cpl_rd]`==`cpl_tag`. WAW: an older completion never clears a newer owner's pending bit.
- Simultaneous events:
  - Issue and completion to the same rd in one cycle: the issue's `pend` set and `owner` write win.
  - A tag freed in cycle N is allocatable from cycle N+1; the free list is never bypassed.
  - Two channels completing the same tag in one cycle: set `err` and apply neither completion.
- `inflight` = popcount of `tag_busy`, maintained incrementally as +issue −(number of legal completions). It is never negative and never exceeds `2**TAG_W`.
- Hazard: `data_stall` = OR over s∈{rs1,rs2} of `used_s` && s≠0 && `pend[s]`.
  - With `CPL_BYPASS`=1, a source is masked when a legal completion this cycle clears that register.
- `data_stall` and `tag_stall` are combinational from registered state plus the ID and completion inputs. They have no dependence on `iss_*`, so no combinational loop exists with the stall path.

## Timing
- Reset, in the cycle after `rst` is high:
  - all `pend`, `tag_busy` cleared;
  - `inflight`=0, `err`=0, `tag_avail`=1, `iss_tag`=0, `data_stall`=0, `tag_stall`=0.
- Reset mid-operation discards every in-flight tag. Completions arriving after reset for pre-reset tags set `err`, so the integration must quiesce the producers.
- Issue in cycle N: a consumer in ID sees `data_stall` from cycle N+1.
- Completion in cycle N:
  - `CPL_BYPASS`=1: the stall drops in cycle N.
  - `CPL_BYPASS`=0: the stall drops in N+1. This mode exists to cut the completion→stall path for fmax.
- Full pool: `tag_avail` falls in the cycle after the last free tag is issued. It rises the cycle after any legal completion.

## Test plan
1. After reset, with `rs1_id`=5 used and no issues → `data_stall`=0, `iss_tag`=0, `inflight`=0.
2. Issue rd=5 (tag 0), hold `rs1_id`=5 used for 3 cycles → `data_stall`=1. Complete tag 0, rd 5 → `data_stall`=0 in the same cycle (`CPL_BYPASS`=1) or the next (`CPL_BYPASS`=0); `inflight` returns to 0.
3. WAW ordering:
   - Issue rd=7 twice, getting tags 0 and 1. Complete tag 0 → `pend[7]` stays 1 and `data_stall` persists for `rs2`=7.
   - Complete tag 1 → clear.
4. Fill all 8 tags (`TAG_W`=3) → `tag_avail`=0, and `tag_stall`=1 when `is_long_id`=1.
   - Complete tag 3 on channel 1 → next cycle `iss_tag`=3 and `tag_avail`=1.
5. Same-cycle events:
   - Complete tag 2 (rd 9) while issuing new rd=9 → `pend[9]`=1 and owner = the new tag.
   - Two channels completing different tags in one cycle → `inflight` drops by 2.
6. Errors and reset:
   - Complete a free tag, or a busy tag with the wrong rd → `err`=1 and the state is unchanged.
   - Assert `rst` with 4 tags in flight → all outputs return to their reset values in the next cycle.
